// File: rtl/sme_operand_collect.sv
// sme_operand_collect
//   Operand collection stage in front of the SME ALU. It accepts one decoded
//   instruction, reads its rs1/rs2 shares one index per cycle from the
//   single-read-port share bank, and buffers them. It then presents the
//   complete share arrays to the ALU with a valid/ready handshake. Share
//   indices beyond the effective share count stay zero. The buffers are
//   scrubbed after every issue and on flush.
//
// Ports
//   g_clk, g_resetn         clock, asynchronous active-low reset
//   flush                   abort the operation and discard all buffered state
//   smectl_d                requested share count, sampled at request accept
//   req_valid/req_ready     instruction handshake (req_op, req_shamt)
//   rf_rd_en/rf_rd_idx      share bank read strobe and index
//   rf_rs1/rf_rs2           share bank data, valid the cycle after rf_rd_en
//   alu_valid/alu_ready     operand handshake (alu_op, alu_shamt, alu_rs1/2)
//   busy                    high whenever the collector is not idle
module sme_operand_collect #(
   parameter int XLEN = 32,
   parameter int SMAX = 4,
   parameter int OPW  = 16
) (
   input  logic                     g_clk,
   input  logic                     g_resetn,
   input  logic                     flush,
   input  logic [3:0]               smectl_d,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [OPW-1:0]           req_op,
   input  logic [4:0]               req_shamt,
   output logic                     rf_rd_en,
   output logic [$clog2(SMAX)-1:0]  rf_rd_idx,
   input  logic [XLEN-1:0]          rf_rs1,
   input  logic [XLEN-1:0]          rf_rs2,
   output logic                     alu_valid,
   input  logic                     alu_ready,
   output logic [OPW-1:0]           alu_op,
   output logic [4:0]               alu_shamt,
   output logic [SMAX*XLEN-1:0]     alu_rs1,
   output logic [SMAX*XLEN-1:0]     alu_rs2,
   output logic                     busy
);

   localparam int IW = $clog2(SMAX);
   localparam int DW = IW + 1;   // d_eff can equal SMAX, so it needs one extra bit

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_ISSUE = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [IW-1:0]          r_cnt;
   logic [DW-1:0]          r_d_eff;
   logic [DW-1:0]          w_d_eff;
   logic                   r_cap_en;
   logic [IW-1:0]          r_cap_idx;
   logic [SMAX*XLEN-1:0]   r_rs1;
   logic [SMAX*XLEN-1:0]   r_rs2;
   logic [OPW-1:0]         r_op;
   logic [4:0]             r_shamt;
   logic                   w_accept;
   logic                   w_fetch;
   logic                   w_fetch_last;
   logic                   w_handshake;

   // Clamp the requested share count into 1..SMAX.
   always_comb begin
      w_d_eff = DW'(smectl_d);
      if (smectl_d == 4'd0) begin
         w_d_eff = DW'(1);
      end else if (int'(smectl_d) > SMAX) begin
         w_d_eff = DW'(SMAX);
      end
   end

   assign w_fetch_last = ({1'b0, r_cnt} == (r_d_eff - DW'(1)));

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Flush overrides every transition, including a pending accept or handshake.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_fetch     = 1'b0;
      w_handshake = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid && !flush) begin
               w_accept    = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            w_fetch = 1'b1;
            if (w_fetch_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            if (alu_ready && !flush) begin
               w_handshake = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush) begin
         w_state_nxt = S_IDLE;
      end
   end

   // Datapath: request latch, read counter, delayed capture and share buffers.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_cnt     <= '0;
         r_d_eff   <= '0;
         r_cap_en  <= 1'b0;
         r_cap_idx <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_op      <= '0;
         r_shamt   <= '0;
      end else if (flush) begin
         // Dropping r_cap_en discards a capture that is due this cycle.
         r_cnt     <= '0;
         r_cap_en  <= 1'b0;
         r_cap_idx <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_op      <= '0;
         r_shamt   <= '0;
      end else begin
         r_cap_en  <= w_fetch;
         r_cap_idx <= r_cnt;
         if (w_accept) begin
            r_op    <= req_op;
            r_shamt <= req_shamt;
            r_d_eff <= w_d_eff;
            r_cnt   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
         end else if (w_handshake) begin
            r_rs1 <= '0;
            r_rs2 <= '0;
         end else begin
            if (w_fetch) begin
               r_cnt <= r_cnt + IW'(1);
            end
            if (r_cap_en) begin
               for (int i = 0; i < SMAX; i++) begin
                  if (r_cap_idx == IW'(i)) begin
                     r_rs1[i*XLEN +: XLEN] <= rf_rs1;
                     r_rs2[i*XLEN +: XLEN] <= rf_rs2;
                  end
               end
            end
         end
      end
   end

   // While flush is high a request cannot be taken, so req_ready drops with it.
   assign req_ready = (r_state == S_IDLE) && !flush && g_resetn;
   assign rf_rd_en  = w_fetch;
   assign rf_rd_idx = w_fetch ? r_cnt : '0;
   assign alu_valid = (r_state == S_ISSUE);
   assign busy      = (r_state != S_IDLE);
   assign alu_op    = r_op;
   assign alu_shamt = r_shamt;
   assign alu_rs1   = r_rs1;
   assign alu_rs2   = r_rs2;

endmodule

// File: doc/sme_operand_collect.md
Name: sme_operand_collect

Overview:
Operand collection stage directly upstream of the SME ALU. Accepts one decoded SME instruction and reads its rs1/rs2 shares, one share index per cycle, from the single-read-port share register bank. Buffers the shares and presents complete share arrays to the ALU with a valid/ready handshake. Zeroes every share index that is not in use, and scrubs its buffers after each issue and on flush.

Parameters:
XLEN, 32, width of one share.
SMAX, 4, maximum number of hardware shares; a power of two, at least 2.
OPW, 16, width of the packed op-decode bundle forwarded to the ALU.

Ports:
g_clk  in  1  global clock.
g_resetn  in  1  asynchronous active-low reset.
flush  in  1  abort the current operation and discard all buffered state.
smectl_d  in  4  number of shares to use; sampled only at request accept.
req_valid  in  1  decoded instruction available.
req_ready  out  1  collector can accept an instruction.
req_op  in  OPW  packed op-decode bits (op_xor, op_and, and the rest).
req_shamt  in  5  shift/rotate amount.
rf_rd_en  out  1  share bank read strobe.
rf_rd_idx  out  log2(SMAX)  share index to read.
rf_rs1  in  XLEN  rs1 share data; valid the cycle after rf_rd_en.
rf_rs2  in  XLEN  rs2 share data; valid the cycle after rf_rd_en.
alu_valid  out  1  operands complete.
alu_ready  in  1  ALU accepts the operands.
alu_op  out  OPW  registered copy of req_op.
alu_shamt  out  5  registered copy of req_shamt.
alu_rs1  out  SMAX*XLEN  rs1 shares; share i occupies bits [i*XLEN +: XLEN].
alu_rs2  out  SMAX*XLEN  rs2 shares, same packing as alu_rs1.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, g_resetn=0):
  - State is IDLE.
  - Share counter and d_eff are 0.
  - Share buffers, alu_op and alu_shamt are all-zero.
  - alu_valid=0, rf_rd_en=0, busy=0.
  - req_ready=1 once reset is released.
- d_eff is latched at accept: smectl_d==0 gives 1; smectl_d>SMAX gives SMAX; otherwise smectl_d.
- States are IDLE, FETCH, DRAIN and ISSUE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_op, req_shamt and d_eff; clear all share buffers to 0; cnt=0; go to FETCH.
- FETCH:
  - rf_rd_en=1 and rf_rd_idx=cnt each cycle; cnt increments.
  - After issuing idx d_eff-1, go to DRAIN.
- Capture: a 1-cycle-delayed copy of rf_rd_en and rf_rd_idx writes rf_rs1/rf_rs2 into buffer[idx] at the end of the cycle after the read.
- DRAIN: performs the final capture, then goes to ISSUE.
- ISSUE:
  - alu_valid=1.
  - alu_rs1, alu_rs2, alu_op and alu_shamt are stable until the handshake.
  - On alu_valid&&alu_ready: clear all buffers to zero, go to IDLE.
- Latency: request accepted at the end of cycle T gives alu_valid high in cycle T+d_eff+2.
- Throughput: one instruction per d_eff+3 cycles minimum; req_ready is low from FETCH through ISSUE.
- Share indices >= d_eff are 0 at issue.
- Each buffer index is written at most once per instruction.
- rf_rd_idx is 0 whenever rf_rd_en=0.
- flush:
  - Acts in any state, synchronously, with priority over every other event.
  - Next state is IDLE; buffers, alu_op, alu_shamt and cnt are cleared; alu_valid is low next cycle.
  - A capture that is pending in the same cycle is discarded.
  - flush together with req_valid in IDLE: the request is not accepted, so req_ready must be treated as 0 for that cycle.
- Reset asserted mid-operation: immediately forces reset values.
- alu_ready while alu_valid=0 is ignored.
- Changes to smectl_d after accept have no effect on the operation in flight.
- Outputs are driven from registers only, with no combinational path from rf_rs* to alu_rs*. This keeps share recombination glitches off the ALU inputs.

Test Plan:
- smectl_d=2, SMAX=4, rf returns rs1 share i = 0x1000_0000+i and rs2 share i = 0x2000_0000+i → reads idx 0,1 in cycles T+1,T+2; alu_valid in T+4; alu_rs1 = {0,0,0x1000_0001,0x1000_0000}; rs2 likewise.
- smectl_d=0, then smectl_d=9 → d_eff=1 (one read, alu_valid at T+3), then d_eff=4 (four reads, alu_valid at T+6).
- ISSUE held with alu_ready=0 for 5 cycles → outputs stable and req_ready=0; after the handshake, all buffers read 0 and req_ready=1 the next cycle.
- flush in FETCH after 2 of 4 reads → IDLE the next cycle, alu_valid never asserted, buffers 0; a new request then completes correctly.
- g_resetn pulsed low mid-DRAIN, asynchronous to g_clk → all outputs take reset values immediately; no stale shares appear after release.
- Back-to-back requests with alu_ready=1 and smectl_d=4 → one issue every 7 cycles; alu_op/alu_shamt match each request.
